// File: rtl/cajero_ctrl.sv
// ATM session controller: card acceptance, 4-digit PIN entry with three attempts,
// then one deposit or withdrawal against an internal 64-bit balance.
module cajero_ctrl #(
  parameter logic [63:0] BALANCE_INICIAL = 64'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tarjeta_recibida,
  input  logic        tipo_tarjeta,
  input  logic [15:0] pin,
  input  logic [3:0]  digito,
  input  logic        digito_stb,
  input  logic        tipo_transaccion,
  input  logic [31:0] monto,
  input  logic        monto_stb,
  output logic        balance_actualizado,
  output logic        entregar_dinero,
  output logic        fondos_insuficientes,
  output logic        pin_incorrecto,
  output logic        advertencia,
  output logic        bloqueo
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PIN     = 3'd1,
    S_CHECK   = 3'd2,
    S_TRANS   = 3'd3,
    S_BLOCKED = 3'd4
  } state_t;

  state_t      state, state_n;
  logic [15:0] entry, entry_n;
  logic [1:0]  dig_cnt, dig_cnt_n;
  logic [1:0]  fail_cnt, fail_cnt_n;
  logic [63:0] balance, balance_n;
  logic        tipo_lat, tipo_lat_n;
  logic        upd_n, ent_n, fondos_n, inc_n, adv_n, blq_n;
  logic [63:0] monto_ext;

  // Card type is kept for the record only; nothing downstream consumes it.
  logic unused_tipo;
  assign unused_tipo = tipo_lat;

  assign monto_ext = {32'd0, monto};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= S_IDLE;
      entry                <= 16'd0;
      dig_cnt              <= 2'd0;
      fail_cnt             <= 2'd0;
      balance              <= BALANCE_INICIAL;
      tipo_lat             <= 1'b0;
      balance_actualizado  <= 1'b0;
      entregar_dinero      <= 1'b0;
      fondos_insuficientes <= 1'b0;
      pin_incorrecto       <= 1'b0;
      advertencia          <= 1'b0;
      bloqueo              <= 1'b0;
    end else begin
      state                <= state_n;
      entry                <= entry_n;
      dig_cnt              <= dig_cnt_n;
      fail_cnt             <= fail_cnt_n;
      balance              <= balance_n;
      tipo_lat             <= tipo_lat_n;
      balance_actualizado  <= upd_n;
      entregar_dinero      <= ent_n;
      fondos_insuficientes <= fondos_n;
      pin_incorrecto       <= inc_n;
      advertencia          <= adv_n;
      bloqueo              <= blq_n;
    end
  end

  always_comb begin
    state_n    = state;
    entry_n    = entry;
    dig_cnt_n  = dig_cnt;
    fail_cnt_n = fail_cnt;
    balance_n  = balance;
    tipo_lat_n = tipo_lat;
    upd_n      = 1'b0;
    ent_n      = 1'b0;
    fondos_n   = 1'b0;
    inc_n      = 1'b0;
    adv_n      = advertencia;
    blq_n      = bloqueo;

    case (state)
      S_IDLE: begin
        if (tarjeta_recibida) begin
          tipo_lat_n = tipo_tarjeta;
          dig_cnt_n  = 2'd0;
          fail_cnt_n = 2'd0;
          state_n    = S_PIN;
        end
      end
      S_PIN: begin
        if (digito_stb) begin
          entry_n   = {entry[11:0], digito};
          dig_cnt_n = dig_cnt + 2'd1;
          if (dig_cnt == 2'd3) state_n = S_CHECK;
        end
      end
      S_CHECK: begin
        dig_cnt_n = 2'd0;
        if (entry == pin) begin
          fail_cnt_n = 2'd0;
          adv_n      = 1'b0;
          state_n    = S_TRANS;
        end else begin
          fail_cnt_n = fail_cnt + 2'd1;
          inc_n      = 1'b1;
          case (fail_cnt_n)
            2'd1: state_n = S_PIN;
            2'd2: begin
              adv_n   = 1'b1;
              state_n = S_PIN;
            end
            default: begin
              adv_n   = 1'b0;
              blq_n   = 1'b1;
              state_n = S_BLOCKED;
            end
          endcase
        end
      end
      S_TRANS: begin
        if (monto_stb) begin
          if (!tipo_transaccion) begin
            balance_n = balance + monto_ext;
            upd_n     = 1'b1;
          end else if (monto_ext <= balance) begin
            balance_n = balance - monto_ext;
            upd_n     = 1'b1;
            ent_n     = 1'b1;
          end else begin
            fondos_n = 1'b1;
          end
          state_n = S_IDLE;
        end
      end
      S_BLOCKED: blq_n = 1'b1;
      default:   state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cajero_ctrl.sv
// Directed plus randomized bench for cajero_ctrl against a session-level model
// of balance, attempt count and warning/block levels.
module tb_cajero_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tarjeta_recibida = 1'b0;
  logic        tipo_tarjeta = 1'b0;
  logic [15:0] pin = 16'h1234;
  logic [3:0]  digito = 4'd0;
  logic        digito_stb = 1'b0;
  logic        tipo_transaccion = 1'b0;
  logic [31:0] monto = 32'd0;
  logic        monto_stb = 1'b0;
  logic        balance_actualizado, entregar_dinero, fondos_insuficientes;
  logic        pin_incorrecto, advertencia, bloqueo;

  int n_asserts = 0;
  int n_fails   = 0;

  // reference model state
  logic [63:0] m_bal;
  int          m_fails;
  logic        m_adv, m_blq;

  cajero_ctrl dut (
    .clk(clk), .rst(rst),
    .tarjeta_recibida(tarjeta_recibida), .tipo_tarjeta(tipo_tarjeta),
    .pin(pin), .digito(digito), .digito_stb(digito_stb),
    .tipo_transaccion(tipo_transaccion), .monto(monto), .monto_stb(monto_stb),
    .balance_actualizado(balance_actualizado), .entregar_dinero(entregar_dinero),
    .fondos_insuficientes(fondos_insuficientes), .pin_incorrecto(pin_incorrecto),
    .advertencia(advertencia), .bloqueo(bloqueo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic u, input logic e, input logic f,
                            input logic i);
    chk({tag, ".balance_actualizado"}, balance_actualizado, u);
    chk({tag, ".entregar_dinero"}, entregar_dinero, e);
    chk({tag, ".fondos_insuficientes"}, fondos_insuficientes, f);
    chk({tag, ".pin_incorrecto"}, pin_incorrecto, i);
    chk({tag, ".advertencia"}, advertencia, m_adv);
    chk({tag, ".bloqueo"}, bloqueo, m_blq);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    m_bal = 64'd1000; m_fails = 0; m_adv = 1'b0; m_blq = 1'b0;
    #2 check_outs("reset", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("reset.balance", dut.balance, m_bal);
  endtask

  task automatic card();
    tarjeta_recibida = 1'b1;
    tipo_tarjeta = 1'($urandom);
    @(negedge clk);
    tarjeta_recibida = 1'b0;
    if (!m_blq) m_fails = 0;
  endtask

  task automatic send_digit(input logic [3:0] v);
    digito = v;
    digito_stb = 1'b1;
    @(negedge clk);
    digito_stb = 1'b0;
  endtask

  task automatic attempt(input logic [15:0] d);
    for (int k = 3; k >= 0; k--) send_digit(d[k*4 +: 4]);
    chk("pin.no_early_result", pin_incorrecto, 1'b0);
    @(negedge clk);
    if (d == pin) begin
      m_fails = 0; m_adv = 1'b0;
    end else begin
      m_fails++;
      m_adv = (m_fails == 2);
      m_blq = (m_fails >= 3);
    end
    check_outs("pin.result", 0, 0, 0, d != pin);
    @(negedge clk);
    check_outs("pin.after", 0, 0, 0, 0);
  endtask

  task automatic transact(input logic t, input logic [31:0] a);
    logic u, e, f;
    tipo_transaccion = t;
    monto = a;
    monto_stb = 1'b1;
    @(negedge clk);
    monto_stb = 1'b0;
    u = 0; e = 0; f = 0;
    if (!t) begin
      m_bal = m_bal + {32'd0, a}; u = 1;
    end else if ({32'd0, a} <= m_bal) begin
      m_bal = m_bal - {32'd0, a}; u = 1; e = 1;
    end else begin
      f = 1;
    end
    check_outs("trans.result", u, e, f, 0);
    chk("trans.balance", dut.balance, m_bal);
    @(negedge clk);
    check_outs("trans.after", 0, 0, 0, 0);
  endtask

  // random strobes that must produce no response; card only when allowed
  task automatic noise(input string tag, input bit allow_card, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      tarjeta_recibida = allow_card ? 1'($urandom) : 1'b0;
      digito = 4'($urandom);
      digito_stb = 1'($urandom);
      monto = $urandom_range(0, 100);
      tipo_transaccion = 1'($urandom);
      monto_stb = 1'($urandom);
      @(negedge clk);
      check_outs(tag, 0, 0, 0, 0);
      chk({tag, ".balance"}, dut.balance, m_bal);
    end
    tarjeta_recibida = 1'b0; digito_stb = 1'b0; monto_stb = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] d;
    logic [31:0] a;
    logic        done;

    @(negedge clk);
    do_reset();
    check_outs("idle", 0, 0, 0, 0);

    // deposit, full withdrawal, then refused withdrawal
    pin = 16'h1234;
    card(); attempt(16'h1234); transact(1'b0, 32'd500);
    chk("plan.bal_1500", dut.balance, 64'd1500);
    card(); attempt(16'h1234); transact(1'b1, 32'd1500);
    chk("plan.bal_0", dut.balance, 64'd0);
    card(); attempt(16'h1234); transact(1'b1, 32'd1);

    // two wrong, warning, then correct
    card(); attempt(16'h1235); attempt(16'h1235);
    chk("plan.adv_set", advertencia, 1'b1);
    attempt(16'h1234);
    chk("plan.adv_clear", advertencia, 1'b0);
    transact(1'b0, 32'd77);

    // three wrong locks the card until reset
    card(); attempt(16'h0000); attempt(16'hFFFF); attempt(16'hA234);
    chk("plan.bloqueo", bloqueo, 1'b1);
    noise("blocked", 1'b1, 20);
    do_reset();
    chk("plan.bloqueo_cleared", bloqueo, 1'b0);

    // reset mid-entry drops partial digits
    card(); send_digit(4'h1); send_digit(4'h2);
    do_reset();
    card(); attempt(16'h1234); transact(1'b0, 32'd5);

    // strobes in IDLE are ignored
    noise("idle_noise", 1'b0, 12);

    // randomized sessions
    for (int s = 0; s < 40; s++) begin
      pin = 16'($urandom);
      card();
      done = 1'b0;
      while (!done) begin
        if ($urandom_range(0, 2) != 0) d = pin;
        else d = pin ^ 16'($urandom_range(1, 65535));
        attempt(d);
        if (d == pin) begin
          case ($urandom_range(0, 3))
            0: a = $urandom;
            1: a = (m_bal < 64'h1_0000_0000) ? m_bal[31:0] : 32'hFFFF_FFFF;
            default: a = $urandom_range(0, 3000);
          endcase
          transact(1'($urandom), a);
          done = 1'b1;
        end else if (m_blq) begin
          noise("rand_blocked", 1'b1, 4);
          do_reset();
          done = 1'b1;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
